// File: rtl/des_key_pkg.sv
// DES key schedule shared definitions: FSM state type, shift schedule,
// PC1/PC2 index tables and the two permutation helpers built on them.
package des_key_pkg;

  typedef enum logic {IDLE, RUN} ks_state_t;

  localparam int HALF_W = 28;

  // Bit i set: round i+1 rotates by 2, else by 1.
  localparam logic [15:0] DES_SHIFT_SCHEDULE = 16'h7EFC;

  // Table entries use DES numbering: bit 1 is the MSB.
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // 64-bit key -> C0||D0; parity bits are simply never selected.
  function automatic logic [2*HALF_W-1:0] pc1_permute(
    input logic [63:0] key
  );
    logic [2*HALF_W-1:0] r;
    r = '0;
    for (int i = 0; i < 56; i++)
      r[6'(55 - i)] = key[6'(64 - PC1_TAB[i])];
    return r;
  endfunction

  // C||D -> 48-bit round key.
  function automatic logic [47:0] pc2_permute(
    input logic [2*HALF_W-1:0] cd
  );
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++)
      r[6'(47 - i)] = cd[6'(56 - PC2_TAB[i])];
    return r;
  endfunction

endpackage

// File: rtl/key_half_rotate.sv
// Circular rotate of one key half by 0, 1 or 2 positions.
// Ports: din (half in), amt (0..2), dir (0 left, 1 right), dout (rotated).
module key_half_rotate
  import des_key_pkg::*;
#(
  parameter int W = HALF_W
) (
  input  logic [W-1:0] din,
  input  logic [1:0]   amt,
  input  logic         dir,
  output logic [W-1:0] dout
);

  always_comb begin
    dout = din;
    case ({dir, amt})
      3'b001:  dout = {din[W-2:0], din[W-1]};
      3'b010:  dout = {din[W-3:0], din[W-1:W-2]};
      3'b101:  dout = {din[0], din[W-1:1]};
      3'b110:  dout = {din[1:0], din[W-1:2]};
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/des_key_schedule_seq.sv
// Sequential DES key scheduler: loads one key, streams ROUNDS round keys
// over a valid/ready port, in encrypt (K1..Kn) or decrypt (Kn..K1) order.
// Ports: clk, rst (async high); key_valid/key_ready/key_in/decrypt (key
// load); flush (abort); rk_valid/rk_ready/rk_data/rk_idx (round keys);
// busy (running), done (pulse after the last round-key handshake).
module des_key_schedule_seq
  import des_key_pkg::*;
#(
  parameter int                ROUNDS         = 16,
  parameter logic [ROUNDS-1:0] SHIFT_SCHEDULE = ROUNDS'(DES_SHIFT_SCHEDULE),
  parameter int                SHIFT_TOTAL    = 28
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      key_valid,
  output logic                      key_ready,
  input  logic [63:0]               key_in,
  input  logic                      decrypt,
  input  logic                      flush,
  output logic                      rk_valid,
  input  logic                      rk_ready,
  output logic [47:0]               rk_data,
  output logic [$clog2(ROUNDS)-1:0] rk_idx,
  output logic                      busy,
  output logic                      done
);

  localparam int IW = $clog2(ROUNDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(ROUNDS - 1);

  // Decrypt walks back with right rotations, so the schedule must bring
  // each half exactly once around.
  if ($countones(SHIFT_SCHEDULE) + ROUNDS != SHIFT_TOTAL) begin : g_bad_sched
    $error("des_key_schedule_seq: shift schedule does not sum to SHIFT_TOTAL");
  end
  if (ROUNDS < 2) begin : g_bad_rounds
    $error("des_key_schedule_seq: ROUNDS must be at least 2");
  end

  ks_state_t state_q, state_d;

  logic [HALF_W-1:0]   c_q, d_q;
  logic [HALF_W-1:0]   c_src, d_src;
  logic [HALF_W-1:0]   c_rot, d_rot;
  logic [2*HALF_W-1:0] pc1_cd;
  logic [47:0]         rk_next;
  logic [IW-1:0]       cnt_q, step_idx;
  logic [1:0]          amt;
  logic                dir;
  logic                dec_q;
  logic                done_q;
  logic                accept, hs, last;

  assign accept = (state_q == IDLE) & key_valid & ~flush;
  assign hs     = (state_q == RUN) & rk_ready & ~flush;
  assign last   = (cnt_q == LAST_IDX);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (flush || (hs && last)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    key_ready = (state_q == IDLE);
    busy      = (state_q == RUN);
    rk_valid  = (state_q == RUN);
  end

  assign done = done_q;

  // Rotator source: fresh PC1 halves on load, stored halves while running.
  // Step j = cnt_q+1 uses s[j] forward, s[ROUNDS-j] backward.
  always_comb begin
    pc1_cd   = pc1_permute(key_in);
    c_src    = c_q;
    d_src    = d_q;
    dir      = dec_q;
    step_idx = '0;
    amt      = 2'd0;
    if (state_q == IDLE) begin
      c_src = pc1_cd[2*HALF_W-1:HALF_W];
      d_src = pc1_cd[HALF_W-1:0];
      dir   = decrypt;
      if (!decrypt) amt = SHIFT_SCHEDULE[0] ? 2'd2 : 2'd1;
    end else begin
      step_idx = dec_q ? LAST_IDX - cnt_q : cnt_q + 1'b1;
      amt      = SHIFT_SCHEDULE[step_idx] ? 2'd2 : 2'd1;
    end
    rk_next = pc2_permute({c_rot, d_rot});
  end

  key_half_rotate #(.W(HALF_W)) u_rot_c (
    .din  (c_src),
    .amt  (amt),
    .dir  (dir),
    .dout (c_rot)
  );

  key_half_rotate #(.W(HALF_W)) u_rot_d (
    .din  (d_src),
    .amt  (amt),
    .dir  (dir),
    .dout (d_rot)
  );

  // C/D always hold the halves behind the rk_data being presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q     <= '0;
      d_q     <= '0;
      rk_data <= '0;
      rk_idx  <= '0;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= hs & last;
      if (accept) begin
        c_q     <= c_rot;
        d_q     <= d_rot;
        rk_data <= rk_next;
        cnt_q   <= '0;
        dec_q   <= decrypt;
        rk_idx  <= decrypt ? LAST_IDX : '0;
      end else if (hs && !last) begin
        c_q     <= c_rot;
        d_q     <= d_rot;
        rk_data <= rk_next;
        cnt_q   <= cnt_q + 1'b1;
        rk_idx  <= dec_q ? rk_idx - 1'b1 : rk_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_des_key_schedule_seq.sv
// Self-checking bench for des_key_schedule_seq against a textbook
// DES key-schedule model (cumulative shifts from C0/D0).
module tb_des_key_schedule_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic        key_ready;
  logic [63:0] key_in;
  logic        decrypt;
  logic        flush;
  logic        rk_valid;
  logic        rk_ready;
  logic [47:0] rk_data;
  logic [3:0]  rk_idx;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  localparam logic [63:0] TKEY = 64'h133457799BBCDFF1;
  localparam logic [47:0] K1   = 48'h1B02EFFC7072;
  localparam logic [47:0] K2   = 48'h79AED9DBC9E5;
  localparam logic [47:0] K16  = 48'hCB3D8B0E17F5;

  int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  logic [47:0] ref_rk  [16];
  logic [47:0] obs_seq [16];

  des_key_schedule_seq dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_in    (key_in),
    .decrypt   (decrypt),
    .flush     (flush),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_data   (rk_data),
    .rk_idx    (rk_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [27:0] rotl28(input logic [27:0] v, input int n);
    logic [55:0] w;
    w = {v, v};
    return w[55 - n -: 28];
  endfunction

  // Kn = PC2(C0,D0 each rotated left by the sum of the first n shifts).
  task automatic build_ref(input logic [63:0] k);
    logic [55:0] cd0, cdn;
    int tot;
    for (int i = 0; i < 56; i++) cd0[55 - i] = k[64 - PC1[i]];
    tot = 0;
    for (int n = 0; n < 16; n++) begin
      tot += SHIFTS[n];
      cdn = {rotl28(cd0[55:28], tot % 28), rotl28(cd0[27:0], tot % 28)};
      for (int i = 0; i < 48; i++) ref_rk[n][47 - i] = cdn[56 - PC2[i]];
    end
  endtask

  function automatic logic [63:0] live(input logic [3:0] idx,
                                       input logic [47:0] d);
    return {9'd0, 1'b1, 1'b1, 1'b0, idx, d};
  endfunction

  // Load one key, drain all round keys (optionally with random stalls).
  task automatic run_stream(input string tag, input logic [63:0] k,
                            input logic dec, input bit rnd);
    int got, cyc;
    logic [3:0] n;
    build_ref(k);
    key_in    = k;
    decrypt   = dec;
    key_valid = 1'b1;
    rk_ready  = 1'b0;
    step();
    key_valid = 1'b0;
    key_in    = {$urandom, $urandom};
    decrypt   = ~dec;
    got = 0;
    cyc = 0;
    while (got < 16 && cyc < 400) begin
      n = dec ? 4'(15 - got) : 4'(got);
      chk({tag, " key"}, {9'd0, rk_valid, busy, done, rk_idx, rk_data},
          live(n, ref_rk[n]));
      rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rk_ready) begin
        obs_seq[got] = rk_data;
        got++;
      end
      step();
      cyc++;
    end
    chk({tag, " handshakes"}, 64'(got), 64'd16);
    chk({tag, " end"}, {60'd0, rk_valid, busy, done, key_ready},
        {60'd0, 4'b0011});
    rk_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] kb;
    rst       = 1'b1;
    key_valid = 1'b0;
    key_in    = '0;
    decrypt   = 1'b0;
    flush     = 1'b0;
    rk_ready  = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("reset outs", {9'd0, rk_valid, busy, done, rk_idx, rk_data}, 64'd0);
    rst = 1'b0;
    step();
    chk("post-reset key_ready", {63'd0, key_ready}, 64'd1);

    // Encrypt, full speed
    run_stream("enc", TKEY, 1'b0, 1'b0);
    chk("enc K1", obs_seq[0], K1);
    chk("enc K2", obs_seq[1], K2);
    chk("enc K16", obs_seq[15], K16);
    step();
    chk("done one cycle", {63'd0, done}, 64'd0);

    // Decrypt, full speed
    run_stream("dec", TKEY, 1'b1, 1'b0);
    chk("dec first", obs_seq[0], K16);
    chk("dec last", obs_seq[15], K1);
    step();

    // Back-pressure, same key, then random keys/modes
    run_stream("bp", TKEY, 1'b0, 1'b1);
    chk("bp K1", obs_seq[0], K1);
    chk("bp K16", obs_seq[15], K16);
    for (int r = 0; r < 4; r++) begin
      step();
      run_stream("rnd", {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1);
    end
    step();

    // flush after 5 handshakes
    build_ref(TKEY);
    key_in = TKEY; decrypt = 1'b0; key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    rk_ready  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("pre-flush key", {9'd0, rk_valid, busy, done, rk_idx, rk_data},
          live(4'(i), ref_rk[i]));
      step();
    end
    rk_ready = 1'b0;
    flush    = 1'b1;
    step();
    flush = 1'b0;
    chk("flush state", {60'd0, rk_valid, busy, done, key_ready},
        {60'd0, 4'b0001});
    step();
    chk("flush no done", {63'd0, done}, 64'd0);
    run_stream("post-flush", TKEY, 1'b0, 1'b0);
    chk("post-flush K1", obs_seq[0], K1);
    step();

    // flush in IDLE beats a key offer
    key_in = TKEY; key_valid = 1'b1; flush = 1'b1;
    step();
    chk("idle flush", {61'd0, rk_valid, busy, key_ready}, {61'd0, 3'b001});
    flush = 1'b0; key_valid = 1'b0;
    step();

    // Back-to-back loads with key_valid held high
    kb = {$urandom, $urandom};
    build_ref(TKEY);
    key_in = TKEY; decrypt = 1'b0; key_valid = 1'b1; rk_ready = 1'b1;
    step();
    key_in = kb;
    for (int i = 0; i < 16; i++) begin
      chk("b2b key A", {9'd0, rk_valid, busy, done, rk_idx, rk_data},
          live(4'(i), ref_rk[i]));
      step();
    end
    chk("b2b done", {61'd0, done, key_ready, rk_valid}, {61'd0, 3'b110});
    build_ref(kb);
    step();
    key_valid = 1'b0;
    chk("b2b key B K1", {9'd0, rk_valid, busy, done, rk_idx, rk_data},
        live(4'd0, ref_rk[0]));

    // flush together with a handshake: flush wins
    flush = 1'b1;
    step();
    flush = 1'b0; rk_ready = 1'b0;
    chk("flush+hs", {60'd0, rk_valid, busy, done, key_ready},
        {60'd0, 4'b0001});

    // Async reset in the middle of a run
    key_in = TKEY; decrypt = 1'b0; key_valid = 1'b1; rk_ready = 1'b1;
    step();
    key_valid = 1'b0;
    step();
    step();
    chk("pre-reset busy", {63'd0, busy}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async reset outs", {9'd0, rk_valid, busy, done, rk_idx, rk_data},
        64'd0);
    #10 rst = 1'b0;
    step();
    chk("reset release", {61'd0, key_ready, busy, done}, {61'd0, 3'b100});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
